// File: rtl/acl_set_assoc_engine.sv
// Set-associative 5-tuple ACL engine: CRC16 set index, 3-stage lookup pipeline, ADD/DEL/CLEAR config FSM.
// Optional hit/miss statistics counters are built when the ACL_STATS_EN macro is defined.
module acl_set_assoc_engine #(
  parameter int ADDR_WIDTH = 10,
  parameter int KEY_WIDTH  = 104,
  parameter int NUM_WAYS   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [KEY_WIDTH-1:0]        in_key,
  output logic                        res_valid,
  output logic                        res_hit,
  output logic                        res_drop,
  output logic [$clog2(NUM_WAYS)-1:0] res_way,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [1:0]                  cfg_op,
  input  logic [KEY_WIDTH-1:0]        cfg_key,
  input  logic                        cfg_drop,
  output logic                        busy,
  output logic                        cfg_done,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
);

  localparam int WAY_W    = $clog2(NUM_WAYS);
  localparam int NUM_SETS = 1 << ADDR_WIDTH;
  localparam int ENT_W    = KEY_WIDTH + 2;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_DEL   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [1:0] {IDLE, CFG_RD, CFG_WR, CLEAR} state_t;

  // CRC16-CCITT, zero init, key consumed MSB first; only the low bits form the set index.
  function automatic logic [ADDR_WIDTH-1:0] set_index(input logic [KEY_WIDTH-1:0] key);
    logic [15:0] c;
    c = 16'h0000;
    for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ ((c[15] ^ key[i]) ? 16'h1021 : 16'h0000);
    end
    return c[ADDR_WIDTH-1:0];
  endfunction

  state_t                state_q, state_d;
  logic                  s0_valid_q, s0_valid_d;
  logic [KEY_WIDTH-1:0]  s0_key_q, s0_key_d;
  logic [ADDR_WIDTH-1:0] s0_idx_q, s0_idx_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [KEY_WIDTH-1:0]  s1_key_q, s1_key_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_hit_q, res_hit_d;
  logic                  res_drop_q, res_drop_d;
  logic [WAY_W-1:0]      res_way_q, res_way_d;
  logic [1:0]            cfg_op_q, cfg_op_d;
  logic [KEY_WIDTH-1:0]  cfg_key_q, cfg_key_d;
  logic                  cfg_drop_q, cfg_drop_d;
  logic [ADDR_WIDTH-1:0] cfg_idx_q, cfg_idx_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic [WAY_W-1:0]      victim_q [NUM_SETS];

  logic                  victim_we;
  logic [ADDR_WIDTH-1:0] victim_addr;
  logic [WAY_W-1:0]      victim_d;
  logic [WAY_W-1:0]      victim_sel;

  logic [NUM_WAYS-1:0]   wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ENT_W-1:0]      wr_data;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [KEY_WIDTH-1:0]  cmp_key;

  logic [NUM_WAYS-1:0]   match_vec;
  logic [NUM_WAYS-1:0]   valid_vec;
  logic [NUM_WAYS-1:0]   drop_vec;
  logic                  match_any, free_any, match_drop;
  logic [WAY_W-1:0]      match_way, free_way;

  logic                  pipe_busy, in_fire, cfg_fire;
  logic [ADDR_WIDTH-1:0] in_idx, cfg_idx;

  assign in_idx  = set_index(in_key);
  assign cfg_idx = set_index(cfg_key);

  // The single read port serves the config read in CFG_RD and lookup stage S0 otherwise.
  assign rd_addr = (state_q == CFG_RD) ? cfg_idx_q : s0_idx_q;
  assign cmp_key = (state_q == CFG_WR) ? cfg_key_q : s1_key_q;

  // One block RAM per way; entry layout is {valid, drop, key}.
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    logic [ENT_W-1:0] mem [NUM_SETS];
    logic [ENT_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_en[gi]) begin
        mem[wr_addr] <= wr_data;
      end
      rd_q <= mem[rd_addr];
    end

    assign valid_vec[gi] = rd_q[ENT_W-1];
    assign drop_vec[gi]  = rd_q[ENT_W-2];
    assign match_vec[gi] = rd_q[ENT_W-1] && (rd_q[KEY_WIDTH-1:0] == cmp_key);
  end

  always_comb begin
    match_any = 1'b0;
    match_way = '0;
    free_any  = 1'b0;
    free_way  = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match_vec[w]) begin
        match_any = 1'b1;
        match_way = WAY_W'(w);
      end
      if (!valid_vec[w]) begin
        free_any = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign match_drop = drop_vec[match_way];
  assign victim_sel = victim_q[cfg_idx_q];

  assign pipe_busy = s0_valid_q | s1_valid_q | res_valid_q;
  assign in_ready  = (state_q == IDLE) && !cfg_valid;
  assign cfg_ready = (state_q == IDLE) && !pipe_busy;
  assign busy      = (state_q != IDLE) || pipe_busy;
  assign in_fire   = in_valid && in_ready;
  assign cfg_fire  = cfg_valid && cfg_ready;

  always_comb begin
    s0_valid_d  = in_fire;
    s0_key_d    = in_fire ? in_key : s0_key_q;
    s0_idx_d    = in_fire ? in_idx : s0_idx_q;
    s1_valid_d  = s0_valid_q;
    s1_key_d    = s0_key_q;
    res_valid_d = s1_valid_q;
    res_hit_d   = s1_valid_q && match_any;
    res_drop_d  = s1_valid_q && match_any && match_drop;
    res_way_d   = (s1_valid_q && match_any) ? match_way : '0;
  end

  always_comb begin
    state_d     = state_q;
    cfg_op_d    = cfg_op_q;
    cfg_key_d   = cfg_key_q;
    cfg_drop_d  = cfg_drop_q;
    cfg_idx_d   = cfg_idx_q;
    clr_idx_d   = clr_idx_q;
    wr_en       = '0;
    wr_addr     = cfg_idx_q;
    wr_data     = '0;
    victim_we   = 1'b0;
    victim_addr = cfg_idx_q;
    victim_d    = '0;
    cfg_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          cfg_op_d   = cfg_op;
          cfg_key_d  = cfg_key;
          cfg_drop_d = cfg_drop;
          cfg_idx_d  = cfg_idx;
          clr_idx_d  = '0;
          case (cfg_op)
            OP_ADD, OP_DEL: state_d = CFG_RD;
            OP_CLEAR:       state_d = CLEAR;
            default:        state_d = CFG_WR;  // reserved op: done pulse only
          endcase
        end
      end
      CFG_RD: state_d = CFG_WR;
      CFG_WR: begin
        cfg_done = 1'b1;
        state_d  = IDLE;
        if (cfg_op_q == OP_ADD) begin
          wr_data = {1'b1, cfg_drop_q, cfg_key_q};
          if (match_any) begin
            wr_en[match_way] = 1'b1;
          end else if (free_any) begin
            wr_en[free_way] = 1'b1;
          end else begin
            wr_en[victim_sel] = 1'b1;
            victim_we         = 1'b1;
            victim_d          = victim_sel + WAY_W'(1);
          end
        end else if (cfg_op_q == OP_DEL && match_any) begin
          wr_data          = {1'b0, 1'b0, cfg_key_q};
          wr_en[match_way] = 1'b1;
        end
      end
      CLEAR: begin
        wr_en       = '1;
        wr_addr     = clr_idx_q;
        victim_we   = 1'b1;
        victim_addr = clr_idx_q;
        clr_idx_d   = clr_idx_q + ADDR_WIDTH'(1);
        if (clr_idx_q == {ADDR_WIDTH{1'b1}}) begin
          cfg_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s0_valid_q  <= 1'b0;
      s0_key_q    <= '0;
      s0_idx_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_key_q    <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_drop_q  <= 1'b0;
      res_way_q   <= '0;
      cfg_op_q    <= '0;
      cfg_key_q   <= '0;
      cfg_drop_q  <= 1'b0;
      cfg_idx_q   <= '0;
      clr_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      s0_valid_q  <= s0_valid_d;
      s0_key_q    <= s0_key_d;
      s0_idx_q    <= s0_idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_key_q    <= s1_key_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_drop_q  <= res_drop_d;
      res_way_q   <= res_way_d;
      cfg_op_q    <= cfg_op_d;
      cfg_key_q   <= cfg_key_d;
      cfg_drop_q  <= cfg_drop_d;
      cfg_idx_q   <= cfg_idx_d;
      clr_idx_q   <= clr_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        victim_q[s] <= '0;
      end
    end else if (victim_we) begin
      victim_q[victim_addr] <= victim_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_hit   = res_hit_q;
  assign res_drop  = res_drop_q;
  assign res_way   = res_way_q;

`ifdef ACL_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (res_valid_q && res_hit_q && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
    if (res_valid_q && !res_hit_q && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_acl_set_assoc_engine.sv
// Scoreboard bench for acl_set_assoc_engine: directed config/lookup vectors, decoupled result monitor.
module tb_acl_set_assoc_engine;
  localparam int AW = 10;
  localparam int KW = 104;
  localparam int NW = 4;
  localparam int WW = 2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_DEL = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [KW-1:0] in_key;
  logic          res_valid, res_hit, res_drop;
  logic [WW-1:0] res_way;
  logic          cfg_valid, cfg_ready;
  logic [1:0]    cfg_op;
  logic [KW-1:0] cfg_key;
  logic          cfg_drop;
  logic          busy, cfg_done;
  logic [31:0]   hit_count, miss_count;

  acl_set_assoc_engine #(.ADDR_WIDTH(AW), .KEY_WIDTH(KW), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .res_valid(res_valid), .res_hit(res_hit), .res_drop(res_drop), .res_way(res_way),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op), .cfg_key(cfg_key),
    .cfg_drop(cfg_drop), .busy(busy), .cfg_done(cfg_done),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WW+1:0] v;    // {hit, drop, way}
    int            due;
    int            id;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int tally_hit = 0;
  int tally_miss = 0;
  int lk_id = 0;

  logic [KW-1:0] zk [6];
  logic [KW-1:0] k1, k2, k9, kone, poly;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Monitor: pop expected result whenever the DUT presents one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("res%0d_fields", e.id), {60'd0, res_hit, res_drop, res_way}, {60'd0, e.v});
        check($sformatf("res%0d_latency", e.id), 64'(cyc), 64'(e.due));
        if (e.v[WW+1]) tally_hit++;
        else tally_miss++;
        $display("res #%0d cyc=%0d hit=%0d drop=%0d way=%0d", e.id, cyc, res_hit, res_drop, res_way);
      end
    end
  end

  task automatic lookup(input logic [KW-1:0] key, input logic h, input logic d, input logic [WW-1:0] w);
    bit   ok = 1'b0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_key   = key;
    for (int t = 0; t < 2000 && !ok; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (in_ready) ok = 1'b1;
    end
    check("lookup_accept", 64'(ok), 64'd1);
    if (ok) begin
      e.v   = {h, d, w};
      e.due = cyc + 3;
      e.id  = lk_id++;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic cfg_issue(input logic [1:0] op, input logic [KW-1:0] key, input logic drop,
                           input bit chk_in_ready, output int raise_cyc, output int acc_cyc);
    bit ok = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_op    = op;
    cfg_key   = key;
    cfg_drop  = drop;
    raise_cyc = cyc;
    acc_cyc   = cyc;
    for (int t = 0; t < 2000 && !ok; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (t == 0 && chk_in_ready) check("in_ready_drop", 64'(in_ready), 64'd0);
      if (cfg_ready) begin
        ok      = 1'b1;
        acc_cyc = cyc;
      end
    end
    check("cfg_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic cfg_wait(input string nm, input int acc, input int lat);
    bit seen = 1'b0;
    int dc   = 0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      if (cfg_done) begin
        seen = 1'b1;
        dc   = cyc;
      end
    end
    check({nm, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({nm, "_done_latency"}, 64'(dc - acc), 64'(lat));
      @(negedge clk);
      check({nm, "_done_pulse"}, 64'(cfg_done), 64'd0);
      $display("cfg %s done %0d cycles after accept", nm, dc - acc);
    end
  endtask

  task automatic do_cfg(input string nm, input logic [1:0] op, input logic [KW-1:0] key,
                        input logic drop, input int lat);
    int r, a;
    cfg_issue(op, key, drop, 1'b0, r, a);
    cfg_wait(nm, a, lat);
  endtask

  task automatic check_counts(input string nm);
    repeat (4) @(negedge clk);
`ifdef ACL_STATS_EN
    check({nm, "_hit_count"}, 64'(hit_count), 64'(tally_hit));
    check({nm, "_miss_count"}, 64'(miss_count), 64'(tally_miss));
`else
    check({nm, "_hit_count"}, 64'(hit_count), 64'd0);
    check({nm, "_miss_count"}, 64'(miss_count), 64'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, a;
    rst_n = 1'b0; in_valid = 1'b0; in_key = '0;
    cfg_valid = 1'b0; cfg_op = '0; cfg_key = '0; cfg_drop = 1'b0;

    // Keys differing by multiples of the CRC polynomial share a full CRC of zero -> set 0.
    poly  = 104'h11021;
    zk[0] = '0;
    for (int i = 1; i < 6; i++) zk[i] = poly << (i - 1);
    k1   = 104'hC0A80001_0A000001_1F90_0050_06;
    k2   = k1 ^ poly;
    k9   = k1 ^ 104'h1;
    kone = 104'h1;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_cfg_done", 64'(cfg_done), 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_miss_count", 64'(miss_count), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_cfg_ready", 64'(cfg_ready), 64'd1);

    do_cfg("clear0", OP_CLR, '0, 1'b0, 1 << AW);
    do_cfg("add_k1_d1", OP_ADD, k1, 1'b1, 2);
    lookup(k1, 1'b1, 1'b1, 2'd0);
    lookup(k9, 1'b0, 1'b0, 2'd0);
    check_counts("after_k1");

    do_cfg("add_k1_d0", OP_ADD, k1, 1'b0, 2);
    do_cfg("add_k2_d1", OP_ADD, k2, 1'b1, 2);
    lookup(k1, 1'b1, 1'b0, 2'd0);
    lookup(k2, 1'b1, 1'b1, 2'd1);

    do_cfg("del_k1", OP_DEL, k1, 1'b0, 2);
    lookup(k1, 1'b0, 1'b0, 2'd0);
    lookup(k2, 1'b1, 1'b1, 2'd1);
    do_cfg("del_absent", OP_DEL, k9, 1'b0, 2);
    do_cfg("reserved", OP_RSV, k2, 1'b0, 1);
    lookup(k2, 1'b1, 1'b1, 2'd1);
    check_counts("after_del");

    do_cfg("clear1", OP_CLR, '0, 1'b0, 1 << AW);
    lookup(k2, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < 4; i++) do_cfg($sformatf("add_z%0d", i), OP_ADD, zk[i], 1'(i), 2);
    lookup(zk[0], 1'b1, 1'b0, 2'd0);
    do_cfg("add_z4", OP_ADD, zk[4], 1'b0, 2);
    do_cfg("add_z5", OP_ADD, zk[5], 1'b1, 2);
    lookup(zk[0], 1'b0, 1'b0, 2'd0);
    lookup(zk[1], 1'b0, 1'b0, 2'd0);
    lookup(zk[2], 1'b1, 1'b0, 2'd2);
    lookup(zk[3], 1'b1, 1'b1, 2'd3);
    lookup(zk[4], 1'b1, 1'b0, 2'd0);
    lookup(zk[5], 1'b1, 1'b1, 2'd1);

    // Streaming lookups with a config request raised mid-stream.
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          case (i % 4)
            0: lookup(zk[2], 1'b1, 1'b0, 2'd2);
            1: lookup(zk[3], 1'b1, 1'b1, 2'd3);
            2: lookup(zk[4], 1'b1, 1'b0, 2'd0);
            default: lookup(zk[5], 1'b1, 1'b1, 2'd1);
          endcase
        end
      end
      begin
        int rr, aa;
        repeat (4) @(negedge clk);
        cfg_issue(OP_ADD, kone, 1'b1, 1'b1, rr, aa);
        check("stream_drain_cycles", 64'(aa - rr), 64'd3);
        cfg_wait("stream_add", aa, 2);
      end
    join
    lookup(kone, 1'b1, 1'b1, 2'd0);
    check_counts("after_stream");

    // Reset in the middle of a CLEAR sweep.
    cfg_issue(OP_CLR, '0, 1'b0, 1'b0, r, a);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tally_hit  = 0;
    tally_miss = 0;
    check("midclr_busy", 64'(busy), 64'd0);
    check("midclr_cfg_ready", 64'(cfg_ready), 64'd1);
    check("midclr_cfg_done", 64'(cfg_done), 64'd0);
    check("midclr_hit_count", 64'(hit_count), 64'd0);
    check("midclr_miss_count", 64'(miss_count), 64'd0);
    rst_n = 1'b1;
    do_cfg("clear2", OP_CLR, '0, 1'b0, 1 << AW);
    lookup(zk[3], 1'b0, 1'b0, 2'd0);
    check_counts("final");

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
